// File: rtl/rob_cdb_sink.sv
// rob_cdb_sink -- reorder-buffer completion table at the receiving end of the CDB.
//
// Issue allocates entries in order at the tail. The CDB completes entries out of
// order. Commit drains DONE entries strictly in order from the head.
// Each entry is a small FREE/BUSY/DONE state machine with a value and an
// exception bit. The entries live in an array of rob_cdb_entry instances.
//
// Optional feature: define ROB_CDB_BYPASS_EN to let a CDB write to the BUSY head
// entry present itself on the commit port in the same cycle.
//
// Ports:
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   flush_i              synchronous flush; blocks every handshake and empties the table
//   alloc_*              issue-side allocation handshake; alloc_idx_o is the tail
//   cdb_*                CDB result packet handshake (target index, value, exception)
//   commit_*             in-order commit handshake at the head
//   spurious_o           sticky flag: a CDB write hit an entry that was not BUSY

package len5_pkg;
  localparam int XLEN = 32;
endpackage

// One table entry. Commit has priority over a CDB write, because with the
// bypass a write to the head can retire in the same cycle. Alloc never
// collides with a write, since a FREE entry never takes a write.
module rob_cdb_entry #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            alloc_i,
  input  logic            wr_i,
  input  logic            commit_i,
  input  logic [XLEN-1:0] value_i,
  input  logic            except_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] value_o,
  output logic            except_o
);
  typedef enum logic [1:0] {FREE, BUSY, DONE} st_t;
  st_t st;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st       <= FREE;
      value_o  <= '0;
      except_o <= 1'b0;
    end else if (flush_i) begin
      st <= FREE;
    end else if (commit_i) begin
      st <= FREE;
    end else if (wr_i) begin
      st       <= DONE;
      value_o  <= value_i;
      except_o <= except_i;
    end else if (alloc_i) begin
      st       <= BUSY;
      except_o <= 1'b0;
    end
  end

  assign busy_o = (st == BUSY);
  assign done_o = (st == DONE);
endmodule

module rob_cdb_sink #(
  parameter int ROB_DEPTH = 8,
  parameter int XLEN      = len5_pkg::XLEN,
  parameter int IDX_W     = $clog2(ROB_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             alloc_valid_i,
  output logic             alloc_ready_o,
  output logic [IDX_W-1:0] alloc_idx_o,
  input  logic             cdb_valid_i,
  output logic             cdb_ready_o,
  input  logic [IDX_W-1:0] cdb_rob_idx_i,
  input  logic [XLEN-1:0]  cdb_value_i,
  input  logic             cdb_except_raised_i,
  output logic             commit_valid_o,
  input  logic             commit_ready_i,
  output logic [IDX_W-1:0] commit_idx_o,
  output logic [XLEN-1:0]  commit_value_o,
  output logic             commit_except_o,
  output logic             spurious_o
);
  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(ROB_DEPTH);

  logic [IDX_W-1:0] head_q, tail_q;
  logic [IDX_W:0]   count_q;
  logic             up_q;
  logic             spur_q;

  logic [ROB_DEPTH-1:0]           busy, done, exc;
  logic [ROB_DEPTH-1:0]           alloc_sel, wr_sel, commit_sel;
  logic [ROB_DEPTH-1:0][XLEN-1:0] val;

  logic alloc_fire, cdb_fire, cdb_wr, commit_fire;

  // Outputs stay quiet while reset is held; otherwise an empty table would
  // advertise ready during reset.
  assign alloc_ready_o = rst_n_i && !flush_i && (count_q != FULL);
  assign alloc_idx_o   = tail_q;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;

  assign cdb_ready_o = up_q && !flush_i;
  assign cdb_fire    = cdb_valid_i && cdb_ready_o;
  // A write lands only on a BUSY entry. FREE or DONE targets are dropped and
  // flagged. This includes the entry being allocated in the same cycle, which
  // is still FREE.
  assign cdb_wr      = cdb_fire && busy[cdb_rob_idx_i];

  assign commit_idx_o = head_q;

`ifdef ROB_CDB_BYPASS_EN
  logic byp_hit;
  assign byp_hit         = cdb_wr && (cdb_rob_idx_i == head_q);
  assign commit_valid_o  = (done[head_q] || byp_hit) && (count_q != '0) && !flush_i;
  assign commit_value_o  = byp_hit ? cdb_value_i : val[head_q];
  assign commit_except_o = byp_hit ? cdb_except_raised_i : exc[head_q];
`else
  assign commit_valid_o  = done[head_q] && (count_q != '0) && !flush_i;
  assign commit_value_o  = val[head_q];
  assign commit_except_o = exc[head_q];
`endif

  assign commit_fire = commit_valid_o && commit_ready_i;
  assign spurious_o  = spur_q;

  for (genvar i = 0; i < ROB_DEPTH; i++) begin : g_ent
    assign alloc_sel[i]  = alloc_fire  && (tail_q == IDX_W'(i));
    assign wr_sel[i]     = cdb_wr      && (cdb_rob_idx_i == IDX_W'(i));
    assign commit_sel[i] = commit_fire && (head_q == IDX_W'(i));

    rob_cdb_entry #(.XLEN(XLEN)) u_ent (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .flush_i  (flush_i),
      .alloc_i  (alloc_sel[i]),
      .wr_i     (wr_sel[i]),
      .commit_i (commit_sel[i]),
      .value_i  (cdb_value_i),
      .except_i (cdb_except_raised_i),
      .busy_o   (busy[i]),
      .done_o   (done[i]),
      .value_o  (val[i]),
      .except_o (exc[i])
    );
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      up_q    <= 1'b0;
      spur_q  <= 1'b0;
    end else begin
      // cdb_ready comes up one edge after reset release.
      up_q <= 1'b1;
      if (flush_i) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        spur_q  <= 1'b0;
      end else begin
        if (alloc_fire)  tail_q <= tail_q + 1'b1;
        if (commit_fire) head_q <= head_q + 1'b1;
        if (cdb_fire && !cdb_wr) spur_q <= 1'b1;
        case ({alloc_fire, commit_fire})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end
endmodule

// File: doc/rob_cdb_sink.md
# rob_cdb_sink

Receiving end of the Common Data Bus: a reorder-buffer completion table that accepts CDB result packets, marks the addressed entries done, and releases them strictly in program order on a commit handshake. Entries are allocated in order by issue logic. Results arrive out of order from the CDB. Commit drains from the head. It sits between the CDB output (ROB-facing handshake) and the commit stage.

## Interface
- `ROB_DEPTH`, default 8: number of entries. Must be a power of two and at least 2.
- `XLEN`, default `len5_pkg::XLEN`: result width.
- `IDX_W`, default `$clog2(ROB_DEPTH)`: entry index width.
- `clk_i` in 1: clock. All state is updated on the rising edge.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `flush_i` in 1: synchronous flush that empties the table.
- `alloc_valid_i` in 1: issue requests a new entry.
- `alloc_ready_o` out 1: an entry is available.
- `alloc_idx_o` out IDX_W: index that will be allocated (the tail).
- `cdb_valid_i` in 1: CDB packet valid.
- `cdb_ready_o` out 1: sink accepts the packet.
- `cdb_rob_idx_i` in IDX_W: target entry.
- `cdb_value_i` in XLEN: result value.
- `cdb_except_raised_i` in 1: the instruction raised an exception.
- `commit_valid_o` out 1: head entry is done.
- `commit_ready_i` in 1: commit stage takes the head entry.
- `commit_idx_o` out IDX_W: head index.
- `commit_value_o` out XLEN: head value.
- `commit_except_o` out 1: head exception flag.
- `spurious_o` out 1: sticky error. Set when a CDB write hits an entry that is not BUSY.

## Operation
- Each entry has three states and also holds a value and an exception bit:
  - FREE → BUSY on allocation.
  - BUSY → DONE on a CDB write.
  - DONE → FREE on commit.
- Pointers:
  - `head` and `tail` are IDX_W bits and wrap modulo ROB_DEPTH.
  - `count` is IDX_W+1 bits, range 0..ROB_DEPTH.
- Allocation handshake:
  - `alloc_ready_o` = (count != ROB_DEPTH) && !flush_i. It must not depend on `commit_ready_i`.
  - A fire occurs when `alloc_valid_i` && `alloc_ready_o` are both high. The entry at `tail` becomes BUSY, its exception bit is cleared, and `tail` increments.
- CDB handshake:
  - `cdb_ready_o` is a register that resets to 0 and is set to 1 at the first clock edge after reset release. It is then combinationally masked by `flush_i`.
  - A fire occurs when `cdb_valid_i` && `cdb_ready_o` are both high.
  - If the target entry is BUSY: store value and exception bit, and the entry becomes DONE.
  - Otherwise (FREE or DONE): the write is dropped, no state changes, and `spurious_o` is set.
- Commit handshake:
  - `commit_valid_o` = head entry is DONE && count != 0 && !flush_i.
  - A fire occurs when `commit_valid_o` && `commit_ready_i` are both high. The head entry becomes FREE and `head` increments.
- Count update: increments on an allocation fire only, decrements on a commit fire only, and is unchanged when both fire in the same cycle.
- Same-cycle write to the entry being allocated: that entry is still FREE, so the write counts as spurious.
- Flush:
  - `flush_i` has priority over every other event in its cycle; no handshake fires.
  - At the next edge: all entries are FREE, head = tail = count = 0, and `spurious_o` = 0.
- Reset values:
  - All outputs are 0.
  - All entries are FREE; head, tail and count are 0; value and exception storage is cleared.
  - Reset applies immediately, including in the middle of any operation.

## Timing
- Allocation fire at edge N: the entry is BUSY from cycle N+1.
- CDB fire at edge N: the entry is DONE from N+1. `commit_valid_o` rises no earlier than N+1, unless bypass is enabled (see Configuration).
- `spurious_o` is high from the cycle after the offending fire.
- Full table: `alloc_ready_o` is 0 while count equals ROB_DEPTH, even when a commit fires in the same cycle. It rises the cycle after that commit.
- Empty table: `commit_valid_o` is 0.
- The table sustains one allocation, one CDB write and one commit per cycle.

## Configuration
- `ROB_CDB_BYPASS_EN` defined:
  - A CDB fire targeting a BUSY head entry makes `commit_valid_o` high in the same cycle.
  - `commit_value_o` and `commit_except_o` come from the CDB inputs in that cycle.
  - If commit also fires that cycle, the entry goes straight to FREE.
- Not defined: there is no CDB-to-commit combinational path. Commit of a result is visible one cycle after its CDB write.

## Test plan
- Reset check: assert `rst_n_i` low mid-stream → all outputs 0. The cycle after release `cdb_ready_o`=0; one cycle later it is 1.
- Out-of-order completion: allocate idx 0,1,2, then CDB writes idx 2 (0x33), 0 (0x11), 1 (0x22), `commit_ready_i`=1 → commits in order idx 0,1,2 with values 0x11, 0x22, 0x33.
- Full and wrap-around: ROB_DEPTH=8, allocate 8 → `alloc_ready_o`=0. Complete and commit idx 0 → `alloc_ready_o`=1 the next cycle and `alloc_idx_o`=0. Repeat for 20 entries; every value commits in order.
- Spurious write: CDB write to FREE idx 5, then a second write to DONE idx 0 → both dropped, `spurious_o`=1, stored values unchanged. Flush → `spurious_o`=0 and count=0.
- Flush priority: with 4 BUSY entries, assert `flush_i` together with allocation and CDB valid → no fires. Next cycle count=0, `alloc_idx_o`=0, `commit_valid_o`=0.
- Bypass: CDB write 0xAB to BUSY head with `commit_ready_i`=1. With `ROB_CDB_BYPASS_EN` → commit fires the same cycle with 0xAB. Without the macro → commit fires the next cycle.
